// File: rtl/clk_divider_prog.sv
`default_nettype none
// ============================================================================
//  Module      : clk_divider_prog
//  Description : Runtime-programmable clock divider. Produces a registered
//                divided clock (ratio N >= 2) and a one-cycle tick strobe at
//                each divided-clock rising edge. Ratio changes and stop
//                requests only take effect at period boundaries.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_divider_prog #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_value,
    output logic             clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] div_active,
    output logic             busy
);

    localparam logic [CNT_W-1:0] C_DEFAULT_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] C_MIN_DIV     = CNT_W'(2);
    localparam logic [CNT_W-1:0] C_ONE         = CNT_W'(1);
    localparam logic [CNT_W:0]   C_ONE_W       = (CNT_W+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] w_div_nxt;
    logic [CNT_W-1:0] r_pend;
    logic [CNT_W-1:0] w_pend_nxt;
    logic             r_pend_valid;
    logic             w_pend_valid_nxt;
    logic             r_clk_out;
    logic             w_clk_out_nxt;
    logic             r_tick;
    logic             w_tick_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic [CNT_W-1:0] w_load_val;
    logic             w_boundary;
    logic [CNT_W:0]   w_half_nxt;

    // Ratios 0 and 1 are meaningless for a divider; clamp them to 2.
    assign w_load_val = (div_value < C_MIN_DIV) ? C_MIN_DIV : div_value;

    // Last cycle of the current period while the divider is counting.
    assign w_boundary = (r_state != S_IDLE) && (r_cnt == (r_div - C_ONE));

    // Next-state, next-count and ratio bookkeeping; outputs are derived from
    // the next values so that the registered outputs describe the cycle they
    // appear in.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_div_nxt        = r_div;
        w_pend_nxt       = r_pend;
        w_pend_valid_nxt = r_pend_valid;
        w_half_nxt       = '0;
        w_clk_out_nxt    = 1'b0;
        w_tick_nxt       = 1'b0;
        w_busy_nxt       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (div_load) begin
                    w_div_nxt = w_load_val;
                end
                if (en) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN, S_DRAIN: begin
                if (w_boundary) begin
                    // A load in the boundary cycle beats any older pending one.
                    w_cnt_nxt        = '0;
                    w_pend_valid_nxt = 1'b0;
                    if (div_load) begin
                        w_div_nxt = w_load_val;
                    end else if (r_pend_valid) begin
                        w_div_nxt = r_pend;
                    end
                    w_state_nxt = en ? S_RUN : S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                    if (div_load) begin
                        w_pend_nxt       = w_load_val;
                        w_pend_valid_nxt = 1'b1;
                    end
                    w_state_nxt = en ? S_RUN : S_DRAIN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // High phase length is ceil(N/2); one extra bit avoids overflow at max N.
        w_half_nxt    = ({1'b0, w_div_nxt} + C_ONE_W) >> 1;
        w_busy_nxt    = (w_state_nxt != S_IDLE);
        w_clk_out_nxt = w_busy_nxt && ({1'b0, w_cnt_nxt} < w_half_nxt);
        w_tick_nxt    = w_busy_nxt && (w_cnt_nxt == '0);
    end

    // State, counter, ratio and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_div        <= C_DEFAULT_DIV;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_clk_out    <= 1'b0;
            r_tick       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_div        <= w_div_nxt;
            r_pend       <= w_pend_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_clk_out    <= w_clk_out_nxt;
            r_tick       <= w_tick_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    assign clk_out    = r_clk_out;
    assign tick       = r_tick;
    assign div_active = r_div;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: doc/clk_divider_prog.md
Name: clk_divider_prog

Overview:
Runtime-programmable clock divider. Generalises the fixed divide-by-4 block to any ratio N ≥ 2 set by a register load.
- Generates a registered divided clock `clk_out`, plus a one-cycle `tick` strobe at each `clk_out` rising edge for use as a clock enable.
- Ratio changes and stop requests take effect only at period boundaries, so `clk_out` never glitches or truncates a pulse.
- Sits in the clock/timing area, driving slow peripheral logic (display scan, debouncers, multi-cycle datapath stepping).

Parameters:
CNT_W, 8, width of divide-ratio value and internal period counter
DEFAULT_DIV, 4, ratio loaded at reset; must satisfy 2 ≤ DEFAULT_DIV ≤ 2^CNT_W-1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
en  input  1  run request; high = generate divided clock
div_load  input  1  single-cycle strobe; capture div_value
div_value  input  CNT_W  requested ratio N; 0 and 1 are clamped to 2
clk_out  output  1  divided clock, registered
tick  output  1  one-clk pulse coincident with each clk_out rising edge
div_active  output  CNT_W  ratio currently in effect
busy  output  1  high when state ≠ IDLE

Behaviour:
- Interface: reset is asynchronous, active-high (`reset`); clock is `clk`. All state updates on posedge `clk`.
- Reset values:
  - state = IDLE, cnt = 0, clk_out = 0, tick = 0, busy = 0
  - div_active = DEFAULT_DIV, pending_valid = 0
- Period definition, for active ratio N with H = ceil(N/2):
  - cnt runs 0..N-1.
  - clk_out = 1 for cnt < H, else 0. Odd N gives high = (N+1)/2 cycles, low = (N-1)/2 cycles.
  - tick = 1 only in period cycle cnt = 0.
  - All outputs are registered: they reflect the cnt value of the current cycle, with no combinational path from inputs.
- Boundary = a RUN/DRAIN cycle with cnt = N-1.
- States:
  - IDLE:
    - clk_out = 0, cnt held at 0.
    - en = 1 → RUN; the next cycle is period cycle 0 (clk_out = 1, tick = 1).
  - RUN:
    - cnt increments and wraps to 0 at boundary.
    - en = 0 sampled in any cycle → DRAIN; the current period still completes.
  - DRAIN:
    - Counts exactly as RUN.
    - At boundary: en = 0 → IDLE (clk_out = 0 next cycle); en = 1 → RUN, next period starts seamlessly.
    - en = 1 before boundary → back to RUN, no visible effect on outputs.
- Ratio load (div_value clamped: < 2 → 2):
  - In IDLE: div_active updated next cycle.
  - In RUN/DRAIN, non-boundary cycle: captured into pending; applied to div_active at the next boundary.
  - In a boundary cycle: bypasses pending and applies to the period starting next cycle.
  - Multiple loads before a boundary: last one wins.
- busy = (state ≠ IDLE), registered.
- Reset asserted mid-period: immediate return to reset values, including dropping any pending ratio; no completion of the period.
- Maximum ratio 2^CNT_W-1; cnt never exceeds N-1, so there is no overflow.

Test Plan:
1. Reset, then en = 1 with default N = 4 → clk_out 1,1,0,0 repeating; tick every 4th cycle; busy = 1; div_active = 4.
2. Load N = 5 in IDLE, then en = 1 → clk_out high 3, low 2, period 5; tick spacing 5; div_active = 5 one cycle after load.
3. Running at N = 4, load N = 6 at cnt = 1 → current period stays 4 cycles; next period high 3, low 3; no pulse shorter than 2 cycles.
4. Running at N = 8, drop en at cnt = 2 → clk_out finishes the 4-low phase through cnt = 7, then holds 0; busy falls after boundary; re-raise en before boundary in a second run → continuous clock, no gap.
5. Load div_value = 0 and = 1 → div_active = 2; clk_out toggles every cycle (1,0,1,0); tick every 2 cycles.
6. Assert reset at cnt = 3 of an N = 10 period with a pending load of 7 → outputs at reset values immediately; after release, div_active = 4 and pending discarded.
